// File: rtl/acc_store_unit.sv
// acc_store_unit: snapshots the accumulator on a store request and writes it
// to a byte-wide memory port one beat at a time, little-endian, honouring
// MemReady wait states, then pulses StoreDone for one cycle.
// DataWidth must be an integer multiple of BusWidth.
module acc_store_unit #(
  parameter int DataWidth = 32,
  parameter int BusWidth  = 8,
  parameter int AddrWidth = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 StoreReq,
  input  logic [AddrWidth-1:0] StoreAddr,
  input  logic                 SkipZeroEn,
  input  logic [DataWidth-1:0] ACCDataIn,
  input  logic                 ACCZero,
  input  logic                 MemReady,
  output logic                 MemWrEn,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [BusWidth-1:0]  MemData,
  output logic                 StoreBusy,
  output logic                 StoreDone
);

  localparam int NumBeats = DataWidth / BusWidth;
  localparam int BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                             state_q, state_d;
  logic [BeatW-1:0]                   beat_q, beat_d;
  logic [NumBeats-1:0][BusWidth-1:0]  shadow_q, shadow_d;
  logic [AddrWidth-1:0]               base_q, base_d;
  logic                               memWrEn_q, memWrEn_d;
  logic [AddrWidth-1:0]               memAddr_q, memAddr_d;
  logic [BusWidth-1:0]                memData_q, memData_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic [BeatW-1:0]                   beatNext;

  assign beatNext = beat_q + BeatW'(1);

  // Next-state logic: every output is computed one cycle early here and then
  // registered, so nothing on the memory or control side sees a
  // combinational path from the inputs.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    shadow_d  = shadow_q;
    base_d    = base_q;
    memWrEn_d = 1'b0;
    memAddr_d = '0;
    memData_d = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (StoreReq) begin
          shadow_d = ACCDataIn;
          base_d   = StoreAddr;
          beat_d   = '0;
          busy_d   = 1'b1;
          if (SkipZeroEn && ACCZero) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = WRITE;
            memWrEn_d = 1'b1;
            memAddr_d = StoreAddr;
            memData_d = ACCDataIn[BusWidth-1:0];
          end
        end
      end

      WRITE: begin
        busy_d = 1'b1;
        if (MemReady) begin
          if (beat_q == LastBeat) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            beat_d    = beatNext;
            memWrEn_d = 1'b1;
            memAddr_d = base_q + AddrWidth'(beatNext);
            memData_d = shadow_q[beatNext];
          end
        end else begin
          memWrEn_d = 1'b1;
          memAddr_d = memAddr_q;
          memData_d = memData_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any store in progress at once,
  // so MemWrEn drops without waiting for a clock edge and no StoreDone follows.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      shadow_q  <= '0;
      base_q    <= '0;
      memWrEn_q <= 1'b0;
      memAddr_q <= '0;
      memData_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      shadow_q  <= shadow_d;
      base_q    <= base_d;
      memWrEn_q <= memWrEn_d;
      memAddr_q <= memAddr_d;
      memData_q <= memData_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign MemWrEn   = memWrEn_q;
  assign MemAddr   = memAddr_q;
  assign MemData   = memData_q;
  assign StoreBusy = busy_q;
  assign StoreDone = done_q;

endmodule
